// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: control-bundle layout,
// destination-select encodings, the NOP bundle and hazard FSM states.
package pipe_pkg;

   localparam int CTRL_W = 21;

   // Control bundle bit offsets, LSB first
   localparam int ALU_OP_LO         = 0;
   localparam int ALU_OP_HI         = 3;
   localparam int LOAD_INSTR_BIT    = 4;
   localparam int RF_ENABLE_BIT     = 5;
   localparam int HI_ENABLE_BIT     = 6;
   localparam int LO_ENABLE_BIT     = 7;
   localparam int PC_PLUS8_BIT      = 8;
   localparam int UB_INSTR_BIT      = 9;
   localparam int JALR_JR_BIT       = 10;
   localparam int DEST_REG_LO       = 11;
   localparam int DEST_REG_HI       = 12;
   localparam int OP_H_S_LO         = 13;
   localparam int OP_H_S_HI         = 15;
   localparam int MEM_ENABLE_BIT    = 16;
   localparam int MEM_READWRITE_BIT = 17;
   localparam int MEM_SIZE_LO       = 18;
   localparam int MEM_SIZE_HI       = 19;
   localparam int MEM_SIGNE_BIT     = 20;

   // DESTINATION_REGISTER field encodings
   localparam logic [1:0] DEST_RT   = 2'b00;
   localparam logic [1:0] DEST_RD   = 2'b01;
   localparam logic [1:0] DEST_R31  = 2'b10;
   localparam logic [1:0] DEST_ZERO = 2'b11;

   // A bubble: nothing written, nothing loaded, nothing stored
   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LU_STALL = 2'b01,
      ST_HOLD     = 2'b10
   } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. Register $0 never raises a hazard. Kept stand-alone so
// the forwarding unit can reuse the same compare.
module load_use_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_load,
   input  logic             ex_rf_en,
   input  logic [REG_W-1:0] ex_dest,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_use,
   input  logic             id_rt_use,
   output logic             hazard
);

   logic rs_hit;
   logic rt_hit;

   // Source-operand match against the in-flight load destination
   always_comb begin
      rs_hit = id_rs_use && (id_rs == ex_dest);
      rt_hit = id_rt_use && (id_rt == ex_dest);
      hazard = ex_load && ex_rf_en && (ex_dest != '0) && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall sequencer.
// Optional macro HAZARD_STATS_EN adds a saturating BUBBLE_CNT output.
//
// state       | meaning
// ------------+----------------------------------------------------------
// RUN (00)    | normal capture; a load-use hazard inserts one bubble
// LU_STALL(01)| bubble sits in EX; re-capture the held ID instruction
// HOLD (10)   | data memory busy; EX and front of pipe frozen
//
// Priority each cycle: Reset > FLUSH > MEM_WAIT > hazard > capture.
// When MEM_WAIT drops while in HOLD the cycle behaves like RUN, so a hazard
// still pending against the held load is caught on the release cycle.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CTRL_W = pipe_pkg::CTRL_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [CTRL_W-1:0] ID_CTRL,
   input  logic [DATA_W-1:0] ID_PA,
   input  logic [DATA_W-1:0] ID_PB,
   input  logic [DATA_W-1:0] ID_IMM,
   input  logic [DATA_W-1:0] ID_PC8,
   input  logic [REG_W-1:0]  ID_RS,
   input  logic [REG_W-1:0]  ID_RT,
   input  logic [REG_W-1:0]  ID_RD,
   input  logic              ID_RS_USE,
   input  logic              ID_RT_USE,
   input  logic              FLUSH,
   input  logic              MEM_WAIT,
   output logic [CTRL_W-1:0] EX_CTRL,
   output logic [DATA_W-1:0] EX_PA,
   output logic [DATA_W-1:0] EX_PB,
   output logic [DATA_W-1:0] EX_IMM,
   output logic [DATA_W-1:0] EX_PC8,
   output logic [REG_W-1:0]  EX_DEST,
   output logic              PC_LE,
   output logic              NPC_LE,
   output logic              IFID_LE,
   output logic [1:0]        HAZ_STATE
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]       BUBBLE_CNT
`endif
);

   hz_state_t state_q;
   hz_state_t state_d;

   logic hazard_raw;
   logic hazard;
   logic capture;
   logic bubble;
   logic le;

   function automatic logic [REG_W-1:0] resolve_dest(
      input logic [1:0]       sel,
      input logic [REG_W-1:0] rt,
      input logic [REG_W-1:0] rd
   );
      logic [REG_W-1:0] d;
      case (sel)
         DEST_RT:  d = rt;
         DEST_RD:  d = rd;
         DEST_R31: d = REG_W'(31);
         default:  d = '0;
      endcase
      return d;
   endfunction

   load_use_detect #(
      .REG_W (REG_W)
   ) u_load_use_detect (
      .ex_load   (EX_CTRL[LOAD_INSTR_BIT]),
      .ex_rf_en  (EX_CTRL[RF_ENABLE_BIT]),
      .ex_dest   (EX_DEST),
      .id_rs     (ID_RS),
      .id_rt     (ID_RT),
      .id_rs_use (ID_RS_USE),
      .id_rt_use (ID_RT_USE),
      .hazard    (hazard_raw)
   );

   // EX already holds the bubble in LU_STALL, so never stall twice in a row
   assign hazard = hazard_raw && (state_q != ST_LU_STALL);

   // Next state and per-cycle action; load enables follow in the same cycle
   always_comb begin
      state_d = ST_RUN;
      capture = 1'b1;
      bubble  = 1'b0;
      le      = 1'b1;
      if (!Reset && !FLUSH) begin
         if (MEM_WAIT) begin
            state_d = ST_HOLD;
            capture = 1'b0;
            le      = 1'b0;
         end else if (hazard) begin
            state_d = ST_LU_STALL;
            bubble  = 1'b1;
            le      = 1'b0;
         end
      end
   end

   assign PC_LE     = le;
   assign NPC_LE    = le;
   assign IFID_LE   = le;
   assign HAZ_STATE = state_q;

   // Hazard FSM state register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Pipeline register: data always follows ID on capture, control is
   // replaced by the NOP bundle on bubble or flush
   always_ff @(posedge Clk) begin
      if (Reset) begin
         EX_CTRL <= CTRL_W'(CTRL_NOP);
         EX_PA   <= '0;
         EX_PB   <= '0;
         EX_IMM  <= '0;
         EX_PC8  <= '0;
         EX_DEST <= '0;
      end else if (capture) begin
         EX_PA  <= ID_PA;
         EX_PB  <= ID_PB;
         EX_IMM <= ID_IMM;
         EX_PC8 <= ID_PC8;
         if (FLUSH || bubble) begin
            EX_CTRL <= CTRL_W'(CTRL_NOP);
         end else begin
            EX_CTRL <= ID_CTRL;
         end
         if (FLUSH) begin
            EX_DEST <= '0;
         end else begin
            EX_DEST <= resolve_dest(ID_CTRL[DEST_REG_HI:DEST_REG_LO], ID_RT, ID_RD);
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] bubble_cnt_q;

   // Saturating count of inserted load-use bubbles
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bubble_cnt_q <= '0;
      end else if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
   end

   assign BUBBLE_CNT = bubble_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the MIPS pipeline, fed by the control-unit NOP mux and the register-file/decode outputs. Consumed by the ALU/EX stage.
- Latches the 21-bit control bundle, operands, immediate, PC+8 and register numbers every cycle.
- Contains the load-use hazard detector and stall sequencer. Drives the load enables of PC, nPC and IF/ID.
- Supports bubble insertion, flush and a memory-wait freeze.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_W, 5, register-number width
CTRL_W, 21, packed control-bundle width (layout in package)

Ports:
Clk  in  1  pipeline clock, rising-edge active
Reset  in  1  synchronous, active-high reset
ID_CTRL  in  CTRL_W  packed control bundle from CU mux
ID_PA  in  DATA_W  register-file port A value
ID_PB  in  DATA_W  register-file port B value
ID_IMM  in  DATA_W  sign/zero-extended immediate
ID_PC8  in  DATA_W  PC+8 of decoding instruction
ID_RS  in  REG_W  rs field
ID_RT  in  REG_W  rt field
ID_RD  in  REG_W  rd field
ID_RS_USE  in  1  decoding instruction reads rs
ID_RT_USE  in  1  decoding instruction reads rt
FLUSH  in  1  squash instruction entering EX
MEM_WAIT  in  1  data memory busy; freeze front of pipe
EX_CTRL  out  CTRL_W  registered control bundle
EX_PA  out  DATA_W  registered port A
EX_PB  out  DATA_W  registered port B
EX_IMM  out  DATA_W  registered immediate
EX_PC8  out  DATA_W  registered PC+8
EX_DEST  out  REG_W  resolved destination register
PC_LE  out  1  1 = PC register loads
NPC_LE  out  1  1 = nPC register loads
IFID_LE  out  1  1 = IF/ID register loads
HAZ_STATE  out  2  current FSM state (debug)

Behaviour:
- Reset (synchronous, active-high, highest priority): all EX_* outputs are 0, EX_CTRL is the NOP bundle (all 0), state is RUN, and PC_LE, NPC_LE and IFID_LE are 1 on the first cycle after reset.
- Latency: one cycle from ID_* inputs to EX_*.
- EX_DEST is resolved at capture from the DESTINATION_REGISTER field:
  - 00 → rt
  - 01 → rd
  - 10 → 5'd31
  - 11 → 0
- Load-use hazard (combinational) = EX LOAD_INSTR & EX RF_ENABLE & EX_DEST≠0 & ((ID_RS_USE & ID_RS==EX_DEST) | (ID_RT_USE & ID_RT==EX_DEST)).
- FSM states:
  - RUN=00: capture ID_*.
    - hazard → load NOP bundle (data fields still captured), drop all three LEs for this cycle, go to LU_STALL.
    - MEM_WAIT → HOLD.
  - LU_STALL=01: LEs high again, capture normally, return to RUN. Exactly one bubble per load-use; no back-to-back bubble because EX now holds the NOP.
  - HOLD=10: all EX_* retained, all LEs 0; stay while MEM_WAIT=1. When MEM_WAIT drops, go to RUN and re-evaluate the hazard that cycle.
- Priority each cycle: Reset > FLUSH > MEM_WAIT > hazard > normal capture.
- FLUSH: load NOP bundle and EX_DEST=0, LEs 1, state RUN, regardless of MEM_WAIT or hazard.
- LEs are combinational from state, hazard and MEM_WAIT. A hazard in RUN lowers them in the same cycle.
- Register $0 is never a hazard source.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds output BUBBLE_CNT (16 bits), a saturating count of load-use bubbles. Cleared by Reset, never wraps; stays at 16'hFFFF once reached.
- Undefined: no port, no counter logic.

Decomposition:
- Package pipe_pkg:
  - CTRL_W and the bundle bit offsets, LSB first: ALU_OP[3:0], LOAD_INSTR, RF_ENABLE, HI_ENABLE, LO_ENABLE, PC_PLUS8_INSTR, UB_INSTR, JALR_JR_INSTR, DESTINATION_REGISTER[1:0], OP_H_S[2:0], MEM_ENABLE, MEM_READWRITE, MEM_SIZE[1:0], MEM_SIGNE.
  - The NOP bundle constant.
  - FSM state encodings.
- Sub-module load_use_detect: the combinational hazard compare, reused later by the forwarding unit.

Test Plan:
- Reset held 2 cycles with ID_PA=32'hDEAD_BEEF → EX_PA=0, EX_CTRL=0, state RUN, LEs=1.
- lw r3 (LOAD_INSTR=1, RF_ENABLE=1, dest=rt=3) then add reading rs=3 → PC_LE/NPC_LE/IFID_LE=0 one cycle, EX_CTRL=NOP next edge, add captured following cycle, EX_DEST=rd.
- lw r0 followed by reader of r0 → no stall, LEs stay 1.
- MEM_WAIT=1 for 3 cycles with EX_PB=32'h0000_0055 → EX_PB stays 0x55, LEs=0 for 3 cycles, HAZ_STATE=10, RUN after release.
- FLUSH=1 together with hazard and MEM_WAIT=1 → EX_CTRL=NOP, EX_DEST=0, LEs=1, state RUN.
- With HAZARD_STATS_EN: 3 load-use pairs → BUBBLE_CNT=3. Preload to 16'hFFFF, one more pair → stays 16'hFFFF.
